qspi_rr_collector: RTL and testbench

//  Parametrised successor of the single-mode collector: gathers finished words from NUM_CH

---
 rtl/qspi_rr_collector.sv | 113 +++++++++++
 tb/tb_qspi_rr_collector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_rr_collector.sv
// Round-robin collector: takes finished words from NUM_CH encrypter channels in strict
// rotation and serialises them MSB-first over LANES data lines through a 2-entry ping-pong buffer.
module qspi_rr_collector #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH*WIDTH-1:0]       enc_data,
    input  logic [NUM_CH-1:0]             enc_data_ready,
    output logic [NUM_CH-1:0]             enc_capture,
    input  logic [$clog2(NUM_CH+1)-1:0]   active_ch,
    input  logic                          flush,
    input  logic                          qspi_ready,
    output logic [LANES-1:0]              qspi_data,
    output logic                          qspi_sending,
    output logic                          busy,
    output logic [CNT_W-1:0]              word_count
);

    localparam int ACT_W  = $clog2(NUM_CH+1);
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BEATS  = WIDTH / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [1:0][WIDTH-1:0] ent_data;
    logic [1:0]            ent_vld;
    logic                  wr_idx;
    logic                  rd_idx;
    logic [PTR_W-1:0]      ptr;
    logic [ACT_W-1:0]      act_q;
    logic [BEAT_W-1:0]     beat;
    logic                  flush_pend;

    logic                  cap_go;
    logic                  beat_go;
    logic                  last_beat;
    logic                  drained;
    logic [PTR_W-1:0]      ptr_nxt;
    logic [ACT_W-1:0]      act_sel;
    logic [WIDTH-1:0]      ptr_word;
    logic [WIDTH-1:0]      shifted;

    assign ptr_word = enc_data[ptr*WIDTH +: WIDTH];

    // A flush arriving this edge also blocks capture, so an idle flush lands ptr on 0 at once.
    assign cap_go = !(&ent_vld) && !(|enc_capture) && !flush_pend && !flush
                    && enc_data_ready[ptr];

    assign ptr_nxt = (int'(ptr) + 1 >= int'(act_q)) ? '0 : ptr + PTR_W'(1);
    assign act_sel = (active_ch == '0 || int'(active_ch) > NUM_CH) ? ACT_W'(NUM_CH) : active_ch;

    assign qspi_sending = ent_vld[rd_idx];
    assign beat_go      = qspi_sending && qspi_ready;
    assign last_beat    = beat_go && (beat == BEAT_W'(BEATS-1));
    assign drained      = !(|ent_vld) && !(|enc_capture);

    assign shifted   = ent_data[rd_idx] << (int'(beat) * LANES);
    assign qspi_data = qspi_sending ? shifted[WIDTH-1 -: LANES] : '0;
    assign busy      = (|ent_vld) || (|enc_capture) || flush_pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_data    <= '0;
            ent_vld     <= '0;
            wr_idx      <= 1'b0;
            rd_idx      <= 1'b0;
            ptr         <= '0;
            act_q       <= ACT_W'(NUM_CH);
            beat        <= '0;
            flush_pend  <= 1'b0;
            enc_capture <= '0;
            word_count  <= '0;
        end else begin
            enc_capture <= '0;

            if (beat_go) begin
                if (last_beat) begin
                    beat            <= '0;
                    ent_vld[rd_idx] <= 1'b0;
                    rd_idx          <= ~rd_idx;
                    word_count      <= word_count + CNT_W'(1);
                end else begin
                    beat <= beat + BEAT_W'(1);
                end
            end

            // Not full pre-edge, so the write slot never collides with the draining entry.
            if (cap_go) begin
                ent_data[wr_idx] <= ptr_word;
                ent_vld[wr_idx]  <= 1'b1;
                wr_idx           <= ~wr_idx;
                enc_capture      <= NUM_CH'(1) << ptr;
                ptr              <= ptr_nxt;
            end

            if (flush || flush_pend) begin
                if (drained) begin
                    ptr        <= '0;
                    flush_pend <= 1'b0;
                end else begin
                    flush_pend <= 1'b1;
                end
            end

            if (!busy && ptr == '0)
                act_q <= act_sel;
        end
    end

endmodule

// File: tb/tb_qspi_rr_collector.sv
// Bench for qspi_rr_collector: a LANES=4 instance for rotation/backpressure/reset and a
// LANES=1 instance for bit-serial output and flush realignment, both scoreboard-checked.
module tb_qspi_rr_collector;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic        bp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [63:0] enc_data;
    logic [1:0]  rdy, cap, act_ch, en;
    logic        flush, qs, busy, bp_mode;
    logic        qr = 1'b1;
    logic [3:0]  qd;
    logic [15:0] wc;

    logic [63:0] enc_data_b;
    logic [1:0]  rdy_b, cap_b, act_b, en_b;
    logic        flush_b, qs_b, busy_b;
    logic        qr_b;
    logic [0:0]  qd_b;
    logic [15:0] wc_b;

    int n_chk = 0;
    int n_fail = 0;
    logic [3:0]  exp_a[$];
    logic        exp_b[$];
    logic [31:0] f0[$], f1[$], g0[$], g1[$];
    int cap_cnt[2];
    int cap_log[$], cap_log_b[$];
    int gaps = 0;
    logic [1:0] cap_prev, cap_prev_b;
    logic hold_v, prev_qs;
    logic [3:0] hold_d;

    qspi_rr_collector #(.NUM_CH(2), .WIDTH(32), .LANES(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .enc_data(enc_data), .enc_data_ready(rdy),
        .enc_capture(cap), .active_ch(act_ch), .flush(flush), .qspi_ready(qr),
        .qspi_data(qd), .qspi_sending(qs), .busy(busy), .word_count(wc));

    qspi_rr_collector #(.NUM_CH(2), .WIDTH(32), .LANES(1), .CNT_W(16)) u_dut_b (
        .clk(clk), .reset(reset), .enc_data(enc_data_b), .enc_data_ready(rdy_b),
        .enc_capture(cap_b), .active_ch(act_b), .flush(flush_b), .qspi_ready(qr_b),
        .qspi_data(qd_b), .qspi_sending(qs_b), .busy(busy_b), .word_count(wc_b));

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, a, e);
        end
    endtask

    task automatic push_a(input logic [31:0] w);
        for (int b = 0; b < 8; b++) exp_a.push_back(w[31-4*b -: 4]);
    endtask

    task automatic push_b(input logic [31:0] w);
        for (int b = 0; b < 32; b++) exp_b.push_back(w[31-b]);
    endtask

    task automatic wait_wc(input logic [15:0] tgt, input string nm);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (wc == tgt) break;
        end
        chk(nm, wc, tgt);
    endtask

    task automatic wait_wc_b(input logic [15:0] tgt, input string nm);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (wc_b == tgt) break;
        end
        chk(nm, wc_b, tgt);
    endtask

    // Channel feeders: present the head word, drop it once its capture pulse is seen.
    always @(negedge clk) begin
        if (cap[0] && f0.size() > 0) void'(f0.pop_front());
        if (cap[1] && f1.size() > 0) void'(f1.pop_front());
        if (cap_b[0] && g0.size() > 0) void'(g0.pop_front());
        if (cap_b[1] && g1.size() > 0) void'(g1.pop_front());
        enc_data[31:0]    = (f0.size() > 0) ? f0[0] : 32'h0;
        enc_data[63:32]   = (f1.size() > 0) ? f1[0] : 32'h0;
        enc_data_b[31:0]  = (g0.size() > 0) ? g0[0] : 32'h0;
        enc_data_b[63:32] = (g1.size() > 0) ? g1[0] : 32'h0;
        rdy   = {en[1] && f1.size() > 0, en[0] && f0.size() > 0};
        rdy_b = {en_b[1] && g1.size() > 0, en_b[0] && g0.size() > 0};
    end

    always @(posedge clk) begin
        #1;
        qr = bp_mode ? ~qr : 1'b1;
    end

    // Output monitors and scoreboard pops.
    always @(negedge clk) begin
        if (!reset) begin
            cap_prev = '0; cap_prev_b = '0; hold_v = 1'b0; prev_qs = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cap[i]) begin
                    cap_cnt[i]++;
                    cap_log.push_back(i);
                    chk("cap_single_cycle", cap_prev[i], 1'b0);
                end
                if (cap_b[i]) cap_log_b.push_back(i);
            end
            cap_prev = cap;
            if (hold_v) chk("bp_hold", qd, hold_d);
            hold_v = qs && !qr;
            hold_d = qd;
            if (prev_qs && !qs && exp_a.size() > 0) gaps++;
            prev_qs = qs;
            if (qs && qr) begin
                if (exp_a.size() == 0) chk("beat_a_extra", qd, 4'hx);
                else chk("beat_a", qd, exp_a.pop_front());
            end
            if (qs_b && qr_b) begin
                if (exp_b.size() == 0) chk("beat_b_extra", qd_b, 1'bx);
                else chk("beat_b", qd_b, exp_b.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        int c0, c1;
        vecs[0] = '{32'hB4352B93, 32'h01234567, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 1'b1};
        vecs[3] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1};
        cap_cnt[0] = 0; cap_cnt[1] = 0;
        reset = 1'b0; en = '0; en_b = '0; act_ch = 2'd2; act_b = 2'd2;
        flush = 1'b0; flush_b = 1'b0; bp_mode = 1'b0; qr_b = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sending", qs, 1'b0);
        chk("rst_data", qd, 4'h0);
        chk("rst_capture", cap, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_word_count", wc, 16'h0);
        reset = 1'b1;

        for (int v = 0; v < 4; v++) begin
            @(posedge clk); #1;
            c0 = cap_cnt[0]; c1 = cap_cnt[1];
            f0.push_back(vecs[v].w0); f1.push_back(vecs[v].w1);
            push_a(vecs[v].w0); push_a(vecs[v].w1);
            bp_mode = vecs[v].bp;
            en = 2'b11;
            wait_wc(wc + 16'd2, "table_word_count");
            chk("table_scoreboard_empty", exp_a.size(), 0);
            chk("table_cap_ch0", cap_cnt[0] - c0, 1);
            chk("table_cap_ch1", cap_cnt[1] - c1, 1);
        end
        bp_mode = 1'b0;
        chk("no_gap", gaps, 0);

        // ch1 offered first must wait behind ch0
        @(posedge clk); #1;
        cap_log.delete();
        en = 2'b10;
        f1.push_back(32'hCAFEF00D); f0.push_back(32'h0BADBEEF);
        push_a(32'h0BADBEEF); push_a(32'hCAFEF00D);
        repeat (10) @(negedge clk);
        chk("order_stall_caps", cap_log.size(), 0);
        chk("order_stall_sending", qs, 1'b0);
        @(posedge clk); #1;
        en = 2'b11;
        wait_wc(wc + 16'd2, "order_word_count");
        chk("order_log_len", cap_log.size(), 2);
        if (cap_log.size() == 2) begin
            chk("order_first", cap_log[0], 0);
            chk("order_second", cap_log[1], 1);
        end

        // single active channel, three back-to-back words
        @(posedge clk); #1;
        act_ch = 2'd1;
        repeat (2) @(posedge clk); #1;
        c0 = cap_cnt[0]; c1 = cap_cnt[1];
        en = 2'b01;
        for (int k = 0; k < 3; k++) begin
            f0.push_back(32'h11111111 * (k + 1));
            push_a(32'h11111111 * (k + 1));
        end
        wait_wc(wc + 16'd3, "act1_word_count");
        chk("act1_caps_ch0", cap_cnt[0] - c0, 3);
        chk("act1_caps_ch1", cap_cnt[1] - c1, 0);
        act_ch = 2'd2;

        // reset asserted mid-word
        @(posedge clk); #1;
        f0.push_back(32'h13579BDF); push_a(32'h13579BDF);
        for (int k = 0; k < 100 && !qs; k++) @(negedge clk);
        chk("midrst_started", qs, 1'b1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("midrst_sending", qs, 1'b0);
        chk("midrst_word_count", wc, 16'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_data", qd, 4'h0);
        f0.delete(); f1.delete(); exp_a.delete(); en = 2'b00;
        @(posedge clk); #1;
        reset = 1'b1;

        // bit-serial instance: flush realigns rotation from ch1 back to ch0
        @(posedge clk); #1;
        cap_log_b.delete();
        en_b = 2'b01;
        g0.push_back(32'h80000001); push_b(32'h80000001);
        for (int k = 0; k < 100 && !qs_b; k++) @(negedge clk);
        chk("flush_started", qs_b, 1'b1);
        repeat (8) @(posedge clk); #1;
        flush_b = 1'b1;
        @(posedge clk); #1;
        flush_b = 1'b0;
        chk("flush_busy", busy_b, 1'b1);
        g1.push_back(32'hA5A5F00F); g0.push_back(32'h0F0F0001);
        push_b(32'h0F0F0001); push_b(32'hA5A5F00F);
        en_b = 2'b11;
        wait_wc_b(16'd3, "flush_word_count");
        chk("flush_scoreboard_empty", exp_b.size(), 0);
        chk("flush_log_len", cap_log_b.size(), 3);
        if (cap_log_b.size() == 3) begin
            chk("flush_cap0", cap_log_b[0], 0);
            chk("flush_cap1", cap_log_b[1], 0);
            chk("flush_cap2", cap_log_b[2], 1);
        end

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
